// File: rtl/anycore_l15_req_sched.sv
// Arbitrates icache, dcache-load and dcache-store requests onto the single L1.5 request port.
// At most one transaction is outstanding; it completes on its response or on a timeout.
module anycore_l15_req_sched #(
    parameter int unsigned PADDR_W = 40,
    parameter int unsigned TMO_W   = 10
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               ic_req_val,
    input  logic [PADDR_W-1:0] ic_req_addr,
    output logic               ic_req_rdy,
    input  logic               ld_req_val,
    input  logic [PADDR_W-1:0] ld_req_addr,
    output logic               ld_req_rdy,
    input  logic               st_req_val,
    input  logic [PADDR_W-1:0] st_req_addr,
    input  logic [63:0]        st_req_data,
    input  logic [2:0]         st_req_size,
    output logic               st_req_rdy,
    output logic               l15_req_val,
    output logic [4:0]         l15_req_rqtype,
    output logic [PADDR_W-1:0] l15_req_address,
    output logic [63:0]        l15_req_data,
    output logic [2:0]         l15_req_size,
    input  logic               l15_req_ack,
    input  logic               l15_resp_val,
    input  logic [3:0]         l15_resp_type,
    output logic               busy,
    output logic               tmo_err
);

    typedef enum logic [1:0] {StIdle, StIssue, StWait} state_e;

    localparam logic [1:0]       SrcIc  = 2'd0;
    localparam logic [1:0]       SrcLd  = 2'd1;
    localparam logic [1:0]       SrcSt  = 2'd2;
    localparam logic [TMO_W-1:0] TmoMax = {TMO_W{1'b1}};

    state_e             state_q, state_d;
    logic [1:0]         ptr_q, ptr_d;
    logic [TMO_W-1:0]   cnt_q, cnt_d;
    logic [4:0]         rqtype_q, rqtype_d;
    logic [3:0]         exp_q, exp_d;
    logic [PADDR_W-1:0] addr_q, addr_d;
    logic [63:0]        data_q, data_d;
    logic [2:0]         size_q, size_d;

    logic       gnt_any;
    logic [1:0] gnt_src;
    logic       resp_match;

    // Round-robin pick: ptr_q names the highest-priority source.
    always_comb begin
        gnt_src = SrcIc;
        unique case (ptr_q)
            SrcLd: begin
                if (ld_req_val)      gnt_src = SrcLd;
                else if (st_req_val) gnt_src = SrcSt;
                else                 gnt_src = SrcIc;
            end
            SrcSt: begin
                if (st_req_val)      gnt_src = SrcSt;
                else if (ic_req_val) gnt_src = SrcIc;
                else                 gnt_src = SrcLd;
            end
            default: begin
                if (ic_req_val)      gnt_src = SrcIc;
                else if (ld_req_val) gnt_src = SrcLd;
                else                 gnt_src = SrcSt;
            end
        endcase
    end

    assign gnt_any    = rst_n && (state_q == StIdle) && (ic_req_val || ld_req_val || st_req_val);
    assign ic_req_rdy = gnt_any && (gnt_src == SrcIc);
    assign ld_req_rdy = gnt_any && (gnt_src == SrcLd);
    assign st_req_rdy = gnt_any && (gnt_src == SrcSt);
    assign resp_match = l15_resp_val && (l15_resp_type == exp_q);

    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        cnt_d    = cnt_q;
        rqtype_d = rqtype_q;
        exp_d    = exp_q;
        addr_d   = addr_q;
        data_d   = data_q;
        size_d   = size_q;
        tmo_err  = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (gnt_any) begin
                    state_d = StIssue;
                    ptr_d   = (gnt_src == SrcSt) ? SrcIc : gnt_src + 2'd1;
                    data_d  = 64'd0;
                    size_d  = 3'b111;
                    unique case (gnt_src)
                        SrcLd: begin
                            rqtype_d = 5'b00000;
                            exp_d    = 4'b0000;
                            addr_d   = ld_req_addr;
                        end
                        SrcSt: begin
                            rqtype_d = 5'b00001;
                            exp_d    = 4'b0100;
                            addr_d   = st_req_addr;
                            data_d   = st_req_data;
                            size_d   = st_req_size;
                        end
                        default: begin
                            rqtype_d = 5'b10000;
                            exp_d    = 4'b0001;
                            addr_d   = ic_req_addr;
                        end
                    endcase
                end
            end
            StIssue: begin
                if (l15_req_ack) begin
                    state_d = StWait;
                    cnt_d   = '0;
                end
            end
            StWait: begin
                // A matching response beats the terminal count in the same cycle.
                if (resp_match) begin
                    state_d = StIdle;
                end else if (cnt_q == TmoMax) begin
                    state_d = StIdle;
                    tmo_err = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            ptr_q    <= SrcIc;
            cnt_q    <= '0;
            rqtype_q <= '0;
            exp_q    <= '0;
            addr_q   <= '0;
            data_q   <= '0;
            size_q   <= '0;
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            cnt_q    <= cnt_d;
            rqtype_q <= rqtype_d;
            exp_q    <= exp_d;
            addr_q   <= addr_d;
            data_q   <= data_d;
            size_q   <= size_d;
        end
    end

    assign l15_req_val     = (state_q == StIssue);
    assign l15_req_rqtype  = l15_req_val ? rqtype_q : 5'd0;
    assign l15_req_address = l15_req_val ? addr_q : '0;
    assign l15_req_data    = l15_req_val ? data_q : 64'd0;
    assign l15_req_size    = l15_req_val ? size_q : 3'd0;
    assign busy            = (state_q != StIdle);

endmodule

// File: tb/tb_anycore_l15_req_sched.sv
// Directed bench for anycore_l15_req_sched: grant, issue, wait, timeout and reset scenarios.
module tb_anycore_l15_req_sched;

    localparam int unsigned PADDR_W = 40;
    localparam int unsigned TMO_W   = 4;

    logic               clk;
    logic               rst_n;
    logic               ic_req_val, ld_req_val, st_req_val;
    logic [PADDR_W-1:0] ic_req_addr, ld_req_addr, st_req_addr;
    logic [63:0]        st_req_data;
    logic [2:0]         st_req_size;
    logic               ic_req_rdy, ld_req_rdy, st_req_rdy;
    logic               l15_req_val;
    logic [4:0]         l15_req_rqtype;
    logic [PADDR_W-1:0] l15_req_address;
    logic [63:0]        l15_req_data;
    logic [2:0]         l15_req_size;
    logic               l15_req_ack;
    logic               l15_resp_val;
    logic [3:0]         l15_resp_type;
    logic               busy;
    logic               tmo_err;

    int tests_run;
    int tests_failed;

    anycore_l15_req_sched #(
        .PADDR_W(PADDR_W),
        .TMO_W  (TMO_W)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .ic_req_val     (ic_req_val),
        .ic_req_addr    (ic_req_addr),
        .ic_req_rdy     (ic_req_rdy),
        .ld_req_val     (ld_req_val),
        .ld_req_addr    (ld_req_addr),
        .ld_req_rdy     (ld_req_rdy),
        .st_req_val     (st_req_val),
        .st_req_addr    (st_req_addr),
        .st_req_data    (st_req_data),
        .st_req_size    (st_req_size),
        .st_req_rdy     (st_req_rdy),
        .l15_req_val    (l15_req_val),
        .l15_req_rqtype (l15_req_rqtype),
        .l15_req_address(l15_req_address),
        .l15_req_data   (l15_req_data),
        .l15_req_size   (l15_req_size),
        .l15_req_ack    (l15_req_ack),
        .l15_resp_val   (l15_resp_val),
        .l15_resp_type  (l15_resp_type),
        .busy           (busy),
        .tmo_err        (tmo_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Inputs change 2 time units after the rising edge; checks happen 1 unit later.
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic clear_inputs();
        ic_req_val    = 1'b0;
        ld_req_val    = 1'b0;
        st_req_val    = 1'b0;
        ic_req_addr   = '0;
        ld_req_addr   = '0;
        st_req_addr   = '0;
        st_req_data   = '0;
        st_req_size   = '0;
        l15_req_ack   = 1'b0;
        l15_resp_val  = 1'b0;
        l15_resp_type = '0;
    endtask

    task automatic do_reset();
        clear_inputs();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    // Called in the first ISSUE cycle: ack at once, then answer with resp_type.
    task automatic finish_txn(input logic [3:0] resp_type);
        l15_req_ack = 1'b1;
        tick();
        l15_req_ack   = 1'b0;
        l15_resp_val  = 1'b1;
        l15_resp_type = resp_type;
        tick();
        l15_resp_val = 1'b0;
    endtask

    task automatic test_reset();
        clear_inputs();
        rst_n      = 1'b0;
        ic_req_val = 1'b1;
        ld_req_val = 1'b1;
        st_req_val = 1'b1;
        tick();
        tick();
        #1;
        tests_run++;
        if ({st_req_rdy, ld_req_rdy, ic_req_rdy} !== 3'b000) begin
            tests_failed++;
            $display("FAIL reset_rdy: got %b want 000", {st_req_rdy, ld_req_rdy, ic_req_rdy});
        end
        tests_run++;
        if ({busy, l15_req_val, tmo_err} !== 3'b000) begin
            tests_failed++;
            $display("FAIL reset_state: busy/val/tmo got %b want 000", {busy, l15_req_val, tmo_err});
        end
        tests_run++;
        if (l15_req_address !== '0 || l15_req_rqtype !== 5'd0) begin
            tests_failed++;
            $display("FAIL reset_payload: addr %h rqtype %b want 0", l15_req_address, l15_req_rqtype);
        end
        ic_req_val  = 1'b0;
        st_req_val  = 1'b0;
        ld_req_addr = 40'h00_1234_5680;
        rst_n       = 1'b1;
        #1;
        tests_run++;
        if (ld_req_rdy !== 1'b1) begin
            tests_failed++;
            $display("FAIL first_grant: ld_req_rdy got %b want 1", ld_req_rdy);
        end
        tick();
        ld_req_val = 1'b0;
        finish_txn(4'b0000);
    endtask

    task automatic test_single_ld();
        do_reset();
        ld_req_val  = 1'b1;
        ld_req_addr = 40'h00_8000_0040;
        #1;
        tests_run++;
        if ({st_req_rdy, ld_req_rdy, ic_req_rdy} !== 3'b010) begin
            tests_failed++;
            $display("FAIL ld_grant: got %b want 010", {st_req_rdy, ld_req_rdy, ic_req_rdy});
        end
        tick();
        ld_req_val = 1'b0;
        #1;
        tests_run++;
        if (l15_req_val !== 1'b1 || l15_req_rqtype !== 5'b00000 || busy !== 1'b1) begin
            tests_failed++;
            $display("FAIL ld_issue: val %b rqtype %b busy %b want 1 00000 1",
                     l15_req_val, l15_req_rqtype, busy);
        end
        tests_run++;
        if (l15_req_address !== 40'h00_8000_0040 || l15_req_size !== 3'b111 ||
            l15_req_data !== 64'd0) begin
            tests_failed++;
            $display("FAIL ld_payload: addr %h size %b data %h want 0080000040 111 0",
                     l15_req_address, l15_req_size, l15_req_data);
        end
        tests_run++;
        if (ld_req_rdy !== 1'b0) begin
            tests_failed++;
            $display("FAIL ld_rdy_one_cycle: got %b want 0", ld_req_rdy);
        end
        tick();
        #1;
        tests_run++;
        if (l15_req_val !== 1'b1) begin
            tests_failed++;
            $display("FAIL ld_hold2: val got %b want 1", l15_req_val);
        end
        tick();
        l15_req_ack = 1'b1;
        #1;
        tests_run++;
        if (l15_req_val !== 1'b1 || l15_req_address !== 40'h00_8000_0040) begin
            tests_failed++;
            $display("FAIL ld_hold3: val %b addr %h want 1 0080000040", l15_req_val, l15_req_address);
        end
        tick();
        l15_req_ack = 1'b0;
        #1;
        tests_run++;
        if (l15_req_val !== 1'b0 || l15_req_address !== '0 || busy !== 1'b1) begin
            tests_failed++;
            $display("FAIL ld_wait: val %b addr %h busy %b want 0 0 1",
                     l15_req_val, l15_req_address, busy);
        end
        repeat (4) tick();
        l15_resp_val  = 1'b1;
        l15_resp_type = 4'b0000;
        #1;
        tests_run++;
        if (busy !== 1'b1) begin
            tests_failed++;
            $display("FAIL ld_busy_resp_cycle: got %b want 1", busy);
        end
        tick();
        l15_resp_val = 1'b0;
        #1;
        tests_run++;
        if (busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL ld_done: busy got %b want 0", busy);
        end
    endtask

    task automatic test_round_robin();
        logic [4:0] rq_exp [3];
        logic [3:0] ret_exp[3];
        rq_exp[0]  = 5'b10000;
        rq_exp[1]  = 5'b00000;
        rq_exp[2]  = 5'b00001;
        ret_exp[0] = 4'b0001;
        ret_exp[1] = 4'b0000;
        ret_exp[2] = 4'b0100;
        do_reset();
        for (int r = 0; r < 2; r++) begin
            ic_req_val  = 1'b1;
            ld_req_val  = 1'b1;
            st_req_val  = 1'b1;
            ic_req_addr = 40'h00_0000_1000;
            ld_req_addr = 40'h00_0000_2000;
            st_req_addr = 40'h00_0000_3000;
            for (int s = 0; s < 3; s++) begin
                #1;
                tests_run++;
                if ({st_req_rdy, ld_req_rdy, ic_req_rdy} !== 3'(1 << s)) begin
                    tests_failed++;
                    $display("FAIL rr_grant r%0d s%0d: got %b want %b", r, s,
                             {st_req_rdy, ld_req_rdy, ic_req_rdy}, 3'(1 << s));
                end
                tick();
                if (s == 0) ic_req_val = 1'b0;
                if (s == 1) ld_req_val = 1'b0;
                if (s == 2) st_req_val = 1'b0;
                #1;
                tests_run++;
                if (l15_req_val !== 1'b1 || l15_req_rqtype !== rq_exp[s] ||
                    {st_req_rdy, ld_req_rdy, ic_req_rdy} !== 3'b000) begin
                    tests_failed++;
                    $display("FAIL rr_issue r%0d s%0d: val %b rqtype %b rdy %b want 1 %b 000", r, s,
                             l15_req_val, l15_req_rqtype, {st_req_rdy, ld_req_rdy, ic_req_rdy},
                             rq_exp[s]);
                end
                l15_req_ack = 1'b1;
                tick();
                l15_req_ack   = 1'b0;
                l15_resp_val  = 1'b1;
                l15_resp_type = ret_exp[s];
                #1;
                if (s < 2) begin
                    tests_run++;
                    if ({st_req_rdy, ld_req_rdy, ic_req_rdy} !== 3'b000) begin
                        tests_failed++;
                        $display("FAIL rr_no_grant_in_wait r%0d s%0d: rdy %b want 000", r, s,
                                 {st_req_rdy, ld_req_rdy, ic_req_rdy});
                    end
                end
                tick();
                l15_resp_val = 1'b0;
            end
        end
    endtask

    task automatic test_store();
        st_req_val  = 1'b1;
        st_req_addr = 40'h00_4000_0100;
        st_req_data = 64'h1122334455667788;
        st_req_size = 3'd3;
        #1;
        tests_run++;
        if (st_req_rdy !== 1'b1) begin
            tests_failed++;
            $display("FAIL st_grant: got %b want 1", st_req_rdy);
        end
        tick();
        st_req_val = 1'b0;
        #1;
        tests_run++;
        if (l15_req_rqtype !== 5'b00001 || l15_req_data !== 64'h1122334455667788 ||
            l15_req_size !== 3'd3 || l15_req_address !== 40'h00_4000_0100) begin
            tests_failed++;
            $display("FAIL st_payload: rqtype %b data %h size %0d addr %h want 00001 1122334455667788 3 0040000100",
                     l15_req_rqtype, l15_req_data, l15_req_size, l15_req_address);
        end
        l15_req_ack = 1'b1;
        tick();
        l15_req_ack   = 1'b0;
        l15_resp_val  = 1'b1;
        l15_resp_type = 4'b0111;
        tick();
        l15_resp_type = 4'b0000;
        tick();
        l15_resp_val = 1'b0;
        #1;
        tests_run++;
        if (busy !== 1'b1 || l15_req_val !== 1'b0) begin
            tests_failed++;
            $display("FAIL st_ignore_other: busy %b val %b want 1 0", busy, l15_req_val);
        end
        l15_resp_val  = 1'b1;
        l15_resp_type = 4'b0100;
        tick();
        l15_resp_val = 1'b0;
        #1;
        tests_run++;
        if (busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL st_ack_done: busy got %b want 0", busy);
        end
    endtask

    task automatic test_timeout();
        ld_req_val  = 1'b1;
        ld_req_addr = 40'h00_0000_5540;
        tick();
        ld_req_val  = 1'b0;
        l15_req_ack = 1'b1;
        tick();
        l15_req_ack = 1'b0;
        // Fifteen silent WAIT cycles with counts 0..14.
        for (int i = 0; i < 15; i++) begin
            #1;
            tests_run++;
            if (tmo_err !== 1'b0) begin
                tests_failed++;
                $display("FAIL tmo_early c%0d: tmo_err got %b want 0", i, tmo_err);
            end
            tick();
        end
        #1;
        tests_run++;
        if (tmo_err !== 1'b1 || busy !== 1'b1) begin
            tests_failed++;
            $display("FAIL tmo_pulse: tmo_err %b busy %b want 1 1", tmo_err, busy);
        end
        tick();
        #1;
        tests_run++;
        if (tmo_err !== 1'b0 || busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL tmo_idle: tmo_err %b busy %b want 0 0", tmo_err, busy);
        end
        ld_req_val = 1'b1;
        tick();
        ld_req_val  = 1'b0;
        l15_req_ack = 1'b1;
        tick();
        l15_req_ack = 1'b0;
        repeat (15) tick();
        l15_resp_val  = 1'b1;
        l15_resp_type = 4'b0000;
        #1;
        tests_run++;
        if (tmo_err !== 1'b0) begin
            tests_failed++;
            $display("FAIL tmo_resp_priority: tmo_err got %b want 0", tmo_err);
        end
        tick();
        l15_resp_val = 1'b0;
        #1;
        tests_run++;
        if (busy !== 1'b0 || tmo_err !== 1'b0) begin
            tests_failed++;
            $display("FAIL tmo_resp_idle: busy %b tmo_err %b want 0 0", busy, tmo_err);
        end
    endtask

    task automatic test_reset_in_wait();
        ld_req_val  = 1'b1;
        ld_req_addr = 40'h00_0000_7780;
        tick();
        ld_req_val  = 1'b0;
        l15_req_ack = 1'b1;
        tick();
        l15_req_ack = 1'b0;
        tick();
        rst_n = 1'b0;
        tick();
        rst_n         = 1'b1;
        l15_resp_val  = 1'b1;
        l15_resp_type = 4'b0000;
        #1;
        tests_run++;
        if ({busy, l15_req_val, tmo_err} !== 3'b000 || l15_req_address !== '0) begin
            tests_failed++;
            $display("FAIL rstw_outputs: busy/val/tmo %b addr %h want 000 0",
                     {busy, l15_req_val, tmo_err}, l15_req_address);
        end
        tick();
        l15_resp_val = 1'b0;
        ic_req_val   = 1'b1;
        ld_req_val   = 1'b1;
        st_req_val   = 1'b1;
        #1;
        tests_run++;
        if (busy !== 1'b0 || {st_req_rdy, ld_req_rdy, ic_req_rdy} !== 3'b001) begin
            tests_failed++;
            $display("FAIL rstw_ptr: busy %b rdy %b want 0 001", busy,
                     {st_req_rdy, ld_req_rdy, ic_req_rdy});
        end
        clear_inputs();
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        rst_n        = 1'b0;
        clear_inputs();
        test_reset();
        test_single_ld();
        test_round_robin();
        test_store();
        test_timeout();
        test_reset_in_wait();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish, want finish before 200000");
        $fatal(1, "timeout");
    end

endmodule
